rr_handshake_arbiter: RTL and testbench
=======================================

// Module: rr_handshake_arbiter
// PURPOSE
//  Round-robin arbiter merging N ready/valid request channels into one
//  registered ready/valid channel, with WIDTH-bit payload and source index.
//  Sits directly upstream of the monitored RTL datapath.
//  Drives that block's handshake_valid and in1 inputs, and consumes its
//  handshake_ready. Uses a 2-entry output buffer to sustain one transfer
//  per cycle.
// PARAMETERS
//  WIDTH   4   payload width per channel
//  N       3   number of request channels (2..8)
//  SELW    2   width of out_sel; must satisfy 2**SELW >= N
// PORTS
//  CLK         in   1         clock, all state on rising edge
//  ASYNCRESET  in   1         asynchronous, active-high reset
//  in_valid    in   N         per-channel valid
//  in_ready    out  N         per-channel ready (grant & ~full)
//  in_data     in   N*WIDTH   channel i at [i*WIDTH +: WIDTH]
//  out_valid   out  1         buffer head valid
//  out_ready   in   1         downstream ready
//  out_data    out  WIDTH     buffer head payload
//  out_sel     out  SELW      source channel of buffer head
//  busy        out  1         any entry buffered (count != 0)
// BEHAVIOUR
//  Reset (async assert, sync-safe release):
//  - count=0, ptr=0, both entries zeroed
//  - out_valid=0, out_data=0, out_sel=0, busy=0
//  - in_ready=0 while ASYNCRESET is high
//  Arbitration (combinational):
//  - grant = first i with in_valid[i], scanning ptr, ptr+1, ... mod N
//  - At most one in_ready bit high per cycle
//  - in_ready[i] = grant[i] & (count<2)
//  Push:
//  - Occurs when in_valid[i] & in_ready[i] on the clock edge
//  - Writes {in_data[i], i} at the tail
//  - Sets ptr <= (i+1) mod N
//  - ptr holds when no push occurs
//  Pop:
//  - Occurs when out_valid & out_ready
//  - Head advances; out_valid = (count!=0)
//  - out_data/out_sel are driven from registered head only
//  - No combinational in->out path
//  Latency:
//  - Accepted beat is visible on out_* one cycle after accept when the
//    buffer was empty
//  - Ordering is FIFO
//  Count update: count' = count + push - pop
//  - Full (count==2): in_ready all 0 even if out_ready=1 the same cycle
//    (full is registered, no ready pass-through)
//  - Empty (count==0): out_valid=0; out_data/out_sel hold last popped value
//  - Simultaneous push+pop at count==1: count stays 1, new beat becomes
//    head next cycle
//  - Wrap: ptr from N-1 goes to 0
//  - Idle inputs never move ptr
//  - Once out_valid=1, out_data/out_sel are stable until popped
//  - Reset mid-transfer discards buffered beats, with no partial output
// TESTING
//  - Reset:
//    - Assert ASYNCRESET mid-cycle with count=2 -> out_valid, busy,
//      in_ready drop immediately
//    - After release, first accepted beat emerges after 1 cycle
//  - Fairness:
//    - in_valid=3'b111 constant, out_ready=1
//    - Grants 0,1,2,0,1,2 and out_sel sequence 0,1,2,0 with throughput
//      1/cycle
//  - Backpressure:
//    - out_ready=0, channel1 sends 4'hA then 4'h5 -> count=2, in_ready=0
//    - out_ready=1 -> out_data A then 5, out_sel=1
//  - Skip idle:
//    - ptr=1, only in_valid[0]=1 with data 4'h3 -> grant 0, ptr becomes 1
//    - out_data=3, out_sel=0
//  - Full boundary: count=2 and out_ready=1 in the same cycle
//    - No push that cycle; count=1 next cycle
//    - Push resumes the following cycle
//  - Push+pop at count==1: count stays 1, order preserved, values 4'h7
//    then 4'hC

Source files
------------

// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter: N ready/valid request channels merged into one registered
// ready/valid output backed by a two-entry buffer (head register + skid entry).
`timescale 1ns/1ps
module rr_handshake_arbiter #(
  parameter int WIDTH = 4,
  parameter int N     = 3,
  parameter int SELW  = 2
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESET,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 busy
);

  logic [1:0]       count;
  logic [SELW-1:0]  ptr;
  logic [WIDTH-1:0] skid_data_p1;
  logic [SELW-1:0]  skid_sel_p1;

  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             grant_any;
  int               idx;
  logic             not_full;
  logic             push;
  logic             pop;

  function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] i);
    logic [SELW-1:0] r;
    if (i == SELW'(N - 1)) r = '0;
    else                   r = i + 1'b1;
    return r;
  endfunction

  // Stage p0: rotating priority scan starting at ptr, first valid channel wins.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    grant_data = '0;
    grant_any  = 1'b0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_any && in_valid[idx]) begin
        grant_any      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = SELW'(idx);
        grant_data     = in_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Readiness comes only from the registered count, so a pop never frees a slot
  // within the same cycle.
  assign not_full  = (count != 2'd2);
  assign in_ready  = grant & {N{not_full & ~ASYNCRESET}};
  assign push      = grant_any & not_full;
  assign out_valid = (count != 2'd0);
  assign busy      = out_valid;
  assign pop       = out_valid & out_ready;

  // Stage p1: head register drives out_* directly; the skid entry holds the
  // second beat. The head keeps the last popped beat when the buffer empties.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      count        <= 2'd0;
      ptr          <= '0;
      out_data     <= '0;
      out_sel      <= '0;
      skid_data_p1 <= '0;
      skid_sel_p1  <= '0;
    end else begin
      if (push) ptr <= wrap_inc(grant_idx);
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            out_data <= grant_data;
            out_sel  <= grant_idx;
            count    <= 2'd1;
          end else begin
            skid_data_p1 <= grant_data;
            skid_sel_p1  <= grant_idx;
            count        <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            out_data <= skid_data_p1;
            out_sel  <= skid_sel_p1;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          // Only reachable at count==1: the incoming beat replaces the popped head.
          out_data <= grant_data;
          out_sel  <= grant_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Randomized and directed bench for rr_handshake_arbiter with a queue scoreboard
// and a behavioural round-robin / FIFO reference model.
`timescale 1ns/1ps
module tb_rr_handshake_arbiter;
  localparam int W    = 4;
  localparam int N    = 3;
  localparam int SELW = 2;
  localparam int D_W  = N * W;

  logic            CLK;
  logic            ASYNCRESET;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [D_W-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            busy;

  rr_handshake_arbiter #(.WIDTH(W), .N(N), .SELW(SELW)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [W+SELW-1:0] q[$];
  int mcount = 0;
  int mptr   = 0;
  int acc_idx = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [D_W-1:0] put(input int ch, input logic [W-1:0] v);
    logic [D_W-1:0] r;
    r = '0;
    r[ch*W +: W] = v;
    return r;
  endfunction

  // Monitor: a handshake seen mid-cycle completes on the next rising edge.
  always @(negedge CLK) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        logic [W+SELW-1:0] e;
        e = q.pop_front();
        chk("out_data", int'(out_data), int'(e[W+SELW-1:SELW]));
        chk("out_sel", int'(out_sel), int'(e[SELW-1:0]));
      end
    end
  end

  // One clock cycle of stimulus; called and returns at 1ns after a rising edge.
  task automatic cycle(input logic [N-1:0] v, input logic [D_W-1:0] d, input logic r);
    logic [N-1:0] exp_rdy;
    int g;
    bit pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    chk("out_valid", int'(out_valid), int'(mcount != 0));
    chk("busy", int'(busy), int'(mcount != 0));
    g = -1;
    exp_rdy = '0;
    if (mcount < 2)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    acc_idx = g;
    if (g >= 0) begin
      q.push_back({d[g*W +: W], SELW'(g)});
      mptr = (g + 1) % N;
    end
    pop = (mcount != 0) && r;
    mcount = mcount + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mcount != 0 && n < 10) begin
      cycle('0, '0, 1'b1);
      n++;
    end
    chk("drain", mcount, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    ASYNCRESET = 1'b1;
    in_valid   = '1;
    in_data    = '0;
    out_ready  = 1'b0;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sel", int'(out_sel), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge CLK);
    #1;
    ASYNCRESET = 1'b0;

    // Fairness with all channels requesting: grants rotate 0,1,2,0,1,2.
    for (int i = 0; i < 6; i++) begin
      cycle('1, D_W'($urandom), 1'b1);
      chk("fair_grant", acc_idx, i % 3);
    end
    drain();

    // Backpressure: channel 1 fills the buffer, then drains A then 5.
    cycle(3'b010, put(1, 4'hA), 1'b0);
    cycle(3'b010, put(1, 4'h5), 1'b0);
    cycle(3'b010, put(1, 4'h9), 1'b0);
    chk("bp_full_no_grant", acc_idx, -1);
    chk("bp_in_ready", int'(in_ready), 0);
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b1);
    drain();

    // Skip idle: move ptr to 1, then only channel 0 requests.
    cycle(3'b001, put(0, 4'h1), 1'b1);
    cycle(3'b001, put(0, 4'h3), 1'b1);
    chk("skip_grant", acc_idx, 0);
    drain();

    // Full boundary: pop while full gives no push; push resumes next cycle.
    cycle('1, D_W'($urandom), 1'b0);
    cycle('1, D_W'($urandom), 1'b0);
    cycle('1, D_W'($urandom), 1'b1);
    chk("full_no_push", acc_idx, -1);
    cycle('1, D_W'($urandom), 1'b1);
    chk("full_push_resumes", int'(acc_idx >= 0), 1);
    drain();

    // Push and pop together at count 1.
    cycle(3'b001, put(0, 4'h7), 1'b0);
    cycle(3'b010, put(1, 4'hC), 1'b1);
    cycle('0, '0, 1'b1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      cycle(N'($urandom), D_W'($urandom), ($urandom_range(0, 3) != 0));
    drain();

    // Reset mid-cycle with a full buffer.
    cycle('1, D_W'($urandom), 1'b0);
    cycle('1, D_W'($urandom), 1'b0);
    in_valid   = '1;
    out_ready  = 1'b1;
    #2;
    ASYNCRESET = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    q.delete();
    mcount = 0;
    mptr   = 0;
    @(posedge CLK);
    #1;
    ASYNCRESET = 1'b0;
    cycle(3'b100, put(2, 4'hE), 1'b0);
    chk("post_rst_out_valid", int'(out_valid), 1);
    chk("post_rst_out_data", int'(out_data), 14);
    chk("post_rst_out_sel", int'(out_sel), 2);
    drain();

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
